// File: rtl/fetch_icache_unit.sv
// -----------------------------------------------------------------------------
// fetch_icache_unit
//
// Instruction-fetch stage with a direct-mapped, read-only instruction cache.
// The PC register is looked up combinationally each cycle. On a hit the cached
// word is presented and the PC advances (or is redirected or held). On a miss
// the whole line is refilled one word at a time from instruction memory, and
// then the lookup is retried.
//
// Address split (low to high):
//   [1:0]                   byte offset (ignored)
//   next log2(WORDS) bits   word offset within the line
//   next log2(LINES) bits   line index
//   remaining bits          tag
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   BranchTarget redirect address, bits [1:0] ignored
//   PcSrc        redirect request (wins over stall)
//   stall        downstream hold, keep current PC (ignored while refilling)
//   hit          current PC is resident in the cache (IDLE only)
//   valid        instruction is usable this cycle (same as hit)
//   instruction  fetched word, 0 when valid=0
//   nextPc       current PC + 4, wraps modulo 2^ADDR_W
//   memReq       refill word request to instruction memory
//   memAddr      word address being requested, 0 when memReq=0
//   memAck       memory returns memData for memAddr this cycle
//   memData      refill data, used only when memReq=1 and memAck=1
// -----------------------------------------------------------------------------
module fetch_icache_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                LINES    = 16,
  parameter int                WORDS    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              PcSrc,
  input  logic              stall,
  output logic              hit,
  output logic              valid,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] nextPc,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [31:0]       memData
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int OFF_LSB = 2;
  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_REFILL = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc;
  logic [0:0]        state;

  logic [LINES-1:0]  line_valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES*WORDS];

  // Line being refilled: its tag, index and the word currently requested.
  logic [TAG_W-1:0]  fill_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [OFF_W-1:0]  fill_cnt;

  // Redirect that arrived while refilling; applied when the refill completes.
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;

  // ---------------------------------------------------------------------------
  // Address decode and lookup
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  pc_idx;
  logic [OFF_W-1:0]  pc_off;
  logic [ADDR_W-1:0] branch_pc;
  logic              lookup_hit;
  logic              refill_fire;
  logic              last_fire;
  logic              target_unused;

  assign pc_tag = pc[ADDR_W-1:TAG_LSB];
  assign pc_idx = pc[TAG_LSB-1:IDX_LSB];
  assign pc_off = pc[IDX_LSB-1:OFF_LSB];

  // Byte-offset bits of the branch target are dropped: fetch is word aligned.
  assign branch_pc     = {BranchTarget[ADDR_W-1:2], 2'b00};
  assign target_unused = ^BranchTarget[1:0];

  // A hit is only reported in IDLE, so nothing half-written is ever visible.
  assign lookup_hit = (state == ST_IDLE) && line_valid[pc_idx]
                      && (tag_mem[pc_idx] == pc_tag);

  // An acknowledge is only meaningful while a request is outstanding.
  assign refill_fire = (state == ST_REFILL) && memAck;
  assign last_fire   = refill_fire && (fill_cnt == LAST_WORD);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign hit         = lookup_hit;
  assign valid       = lookup_hit;
  assign instruction = lookup_hit ? data_mem[{pc_idx, pc_off}] : 32'h0;
  assign nextPc      = pc + ADDR_W'(4);
  assign memReq      = (state == ST_REFILL);
  assign memAddr     = memReq ? {fill_tag, fill_idx, fill_cnt, 2'b00} : '0;

  // ---------------------------------------------------------------------------
  // Control: PC, FSM, valid bits, refill counter, pending redirect
  // ---------------------------------------------------------------------------
  // NOTE: every register below uses non-blocking assignment so that all reads
  // in this block see pre-edge values; a later assignment in the same block
  // (e.g. pend_valid on the final ack) overrides an earlier one.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= ST_IDLE;
      line_valid  <= '0;
      fill_tag    <= '0;
      fill_idx    <= '0;
      fill_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lookup_hit) begin
            if (PcSrc) begin
              pc <= branch_pc;
            end else if (!stall) begin
              pc <= pc + ADDR_W'(4);
            end
          end else if (PcSrc) begin
            // Abandon the missing line without fetching it.
            pc <= branch_pc;
          end else begin
            state    <= ST_REFILL;
            fill_tag <= pc_tag;
            fill_idx <= pc_idx;
            fill_cnt <= '0;
            // Evict now: the line stays invalid until its last word lands.
            line_valid[pc_idx] <= 1'b0;
          end
        end

        ST_REFILL: begin
          // Last redirect seen during the refill wins.
          if (PcSrc) begin
            pend_valid  <= 1'b1;
            pend_target <= branch_pc;
          end
          if (refill_fire) begin
            fill_cnt <= fill_cnt + 1'b1;
          end
          if (last_fire) begin
            line_valid[fill_idx] <= 1'b1;
            state                <= ST_IDLE;
            pend_valid           <= 1'b0;
            if (PcSrc) begin
              pc <= branch_pc;
            end else if (pend_valid) begin
              pc <= pend_target;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tag and data arrays
  // ---------------------------------------------------------------------------
  // NOTE: the arrays carry no reset; their contents are never observed until
  // the matching valid bit is set, which only happens after a full refill.
  always_ff @(posedge clk) begin
    if (!reset && refill_fire) begin
      data_mem[{fill_idx, fill_cnt}] <= memData;
    end
    if (!reset && last_fire) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule
